// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI caches, the snooping bus controller and the status displays.
package mesi_pkg;

  // Per-cache MESI line state
  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_state_e;

  // Bus messages broadcast to the non-owning cache
  typedef enum logic [1:0] {
    BUS_NONE = 2'b00,
    BUS_RD   = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_UPGR = 2'b11
  } bus_msg_e;

  // Commands issued to memory
  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_READ = 2'b01,
    MEM_WB   = 2'b10
  } mem_cmd_e;

  // Cache-side memory request code for an eviction writeback; 01/11 mean nothing
  localparam logic [1:0] MEM_REQ_WB = 2'b10;

  // Bus controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNOOP = 3'd1,
    ST_FLUSH = 3'd2,
    ST_MEM   = 3'd3,
    ST_DONE  = 3'd4
  } bus_state_e;

  // BusRd and BusRdX need the line fetched from memory; BusUpgr only invalidates
  function automatic logic needs_mem_read(input logic [1:0] msg);
    return (msg == BUS_RD) || (msg == BUS_RDX);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter. The priority flop moves to the
// requester that did not own the bus whenever a transaction completes.
module rr_arbiter_2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  output logic       winner,
  output logic       any_req
);

  logic prio_q;
  logic prio_d;

  // Winner selection and next priority (0 = cache 0 favoured)
  always_comb begin
    any_req = |req;
    winner  = (req == 2'b11) ? prio_q : req[1];
    prio_d  = advance ? ~owner : prio_q;
  end

  // Priority register, back to cache 0 on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/mesi_bus_ctrl.sv
// Snooping bus controller: serializes bus and writeback requests from two
// MESI caches, forwards the owner's bus message to the other cache and
// sequences memory flush/read commands. All outputs are registered and are
// decoded from the next state so they line up with the state they describe.
//
// Handshake: a cache requests by holding req_bus != 00 or req_mem == 10 and
// keeps both stable until it sees done; the controller latches the message
// when it grants and ignores later changes. mem_cmd is held until mem_ready
// is sampled high on a rising edge, which retires the command.
module mesi_bus_ctrl
  import mesi_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req0_bus,
  input  logic [1:0]       req0_mem,
  input  logic [1:0]       req1_bus,
  input  logic [1:0]       req1_mem,
  input  logic [1:0]       state0,
  input  logic [1:0]       state1,
  input  logic             mem_ready,
  output logic [1:0]       grant,
  output logic [1:0]       snoop_msg0,
  output logic [1:0]       snoop_msg1,
  output logic             shared,
  output logic [1:0]       mem_cmd,
  output logic             done,
  output logic [CNT_W-1:0] txn_count,
  output bus_state_e       dbg_state
);

  bus_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic [1:0]       msg_q, msg_d;
  logic             shared_q, shared_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       snoop0_q, snoop0_d;
  logic [1:0]       snoop1_q, snoop1_d;
  logic [1:0]       mem_cmd_q, mem_cmd_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] txn_count_q, txn_count_d;

  logic [1:0] req_vec;
  logic       winner;
  logic       any_req;
  logic [1:0] win_msg;
  logic [1:0] other_state;

  // A cache requests with a bus message or a writeback; other mem codes are ignored
  always_comb begin
    req_vec[0]  = (req0_bus != BUS_NONE) || (req0_mem == MEM_REQ_WB);
    req_vec[1]  = (req1_bus != BUS_NONE) || (req1_mem == MEM_REQ_WB);
    win_msg     = winner ? req1_bus : req0_bus;
    other_state = owner_q ? state0 : state1;
  end

  rr_arbiter_2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_vec),
    .advance (done_q),
    .owner   (owner_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Next-state, latched transaction fields and registered-output decode
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    msg_d       = msg_q;
    shared_d    = shared_q;
    txn_count_d = txn_count_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          msg_d   = win_msg;
          // A bus message wins over a writeback from the same cache
          state_d = (win_msg != BUS_NONE) ? ST_SNOOP : ST_FLUSH;
        end
      end
      ST_SNOOP: begin
        shared_d = (msg_q == BUS_RD) && (other_state != MESI_I);
        if (other_state == MESI_M)    state_d = ST_FLUSH;
        else if (needs_mem_read(msg_q)) state_d = ST_MEM;
        else                          state_d = ST_DONE;
      end
      ST_FLUSH: begin
        // Writeback-only transactions carry msg 00 and finish after the flush
        if (mem_ready) state_d = needs_mem_read(msg_q) ? ST_MEM : ST_DONE;
      end
      ST_MEM: begin
        if (mem_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        shared_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Count on entry to DONE so the new value appears with the done pulse
    if ((state_d == ST_DONE) && (state_q != ST_DONE))
      txn_count_d = txn_count_q + CNT_W'(1);

    grant_d   = (state_d == ST_IDLE) ? 2'b00 : (owner_d ? 2'b10 : 2'b01);
    snoop0_d  = ((state_d == ST_SNOOP) &&  owner_d) ? msg_d : 2'b00;
    snoop1_d  = ((state_d == ST_SNOOP) && !owner_d) ? msg_d : 2'b00;
    mem_cmd_d = (state_d == ST_FLUSH) ? MEM_WB :
                (state_d == ST_MEM)   ? MEM_READ : MEM_NONE;
    done_d    = (state_d == ST_DONE);
  end

  // State and output registers; reset clears everything immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      msg_q       <= 2'b00;
      shared_q    <= 1'b0;
      grant_q     <= 2'b00;
      snoop0_q    <= 2'b00;
      snoop1_q    <= 2'b00;
      mem_cmd_q   <= 2'b00;
      done_q      <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      msg_q       <= msg_d;
      shared_q    <= shared_d;
      grant_q     <= grant_d;
      snoop0_q    <= snoop0_d;
      snoop1_q    <= snoop1_d;
      mem_cmd_q   <= mem_cmd_d;
      done_q      <= done_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign grant      = grant_q;
  assign snoop_msg0 = snoop0_q;
  assign snoop_msg1 = snoop1_q;
  assign shared     = shared_q;
  assign mem_cmd    = mem_cmd_q;
  assign done       = done_q;
  assign txn_count  = txn_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// Testbench for mesi_bus_ctrl. Each transaction pushes its expected
// cycle-by-cycle output trace into exp_q; the driver pops one entry per
// cycle on the falling edge and compares it with the DUT outputs.
module tb_mesi_bus_ctrl;
  import mesi_pkg::*;

  localparam int CNT_W = 8;
  localparam int W     = 10 + CNT_W;

  logic             clock, reset;
  logic [1:0]       req0_bus, req0_mem, req1_bus, req1_mem;
  logic [1:0]       state0, state1;
  logic             mem_ready;
  logic [1:0]       grant, snoop_msg0, snoop_msg1, mem_cmd;
  logic             shared, done;
  logic [CNT_W-1:0] txn_count;
  bus_state_e       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]     exp_q[$];
  logic             mr_q[$];
  logic [CNT_W-1:0] exp_count;

  mesi_bus_ctrl #(.CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_bus   (req0_bus),
    .req0_mem   (req0_mem),
    .req1_bus   (req1_bus),
    .req1_mem   (req1_mem),
    .state0     (state0),
    .state1     (state1),
    .mem_ready  (mem_ready),
    .grant      (grant),
    .snoop_msg0 (snoop_msg0),
    .snoop_msg1 (snoop_msg1),
    .shared     (shared),
    .mem_cmd    (mem_cmd),
    .done       (done),
    .txn_count  (txn_count),
    .dbg_state  (dbg_state)
  );

  // Clock and run-time guard
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Output vector layout: {grant, snoop0, snoop1, shared, mem_cmd, done, txn_count}
  function automatic logic [W-1:0] pack(input logic [1:0] g, input logic [1:0] s0,
                                        input logic [1:0] s1, input logic sh,
                                        input logic [1:0] mc, input logic dn,
                                        input logic [CNT_W-1:0] cnt);
    return {g, s0, s1, sh, mc, dn, cnt};
  endfunction

  function automatic logic [W-1:0] observed();
    return pack(grant, snoop_msg0, snoop_msg1, shared, mem_cmd, done, txn_count);
  endfunction

  // Build the expected trace of one transaction, starting with its request cycle in IDLE
  task automatic push_txn(input logic owner, input logic [1:0] msg, input logic [1:0] other_st,
                          input int fw, input int mw);
    logic [1:0] g, s0, s1;
    logic       sh;
    g  = owner ? 2'b10 : 2'b01;
    s0 = owner ? msg : 2'b00;
    s1 = owner ? 2'b00 : msg;
    sh = (msg == 2'b01) && (other_st != 2'b00);
    exp_q.push_back(pack(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, exp_count));
    mr_q.push_back(1'b1);
    if (msg != 2'b00) begin
      exp_q.push_back(pack(g, s0, s1, 1'b0, 2'b00, 1'b0, exp_count));
      mr_q.push_back(1'b1);
    end
    if ((msg == 2'b00) || (other_st == 2'b11)) begin
      for (int i = 0; i <= fw; i++) begin
        exp_q.push_back(pack(g, 2'b00, 2'b00, sh, 2'b10, 1'b0, exp_count));
        mr_q.push_back(i == fw);
      end
    end
    if ((msg == 2'b01) || (msg == 2'b10)) begin
      for (int i = 0; i <= mw; i++) begin
        exp_q.push_back(pack(g, 2'b00, 2'b00, sh, 2'b01, 1'b0, exp_count));
        mr_q.push_back(i == mw);
      end
    end
    exp_count = exp_count + 1'b1;
    exp_q.push_back(pack(g, 2'b00, 2'b00, sh, 2'b00, 1'b1, exp_count));
    mr_q.push_back(1'b1);
  endtask

  // Drive one request (plus an optional competing bus request) and score every cycle
  task automatic run_txn(input logic owner, input logic [1:0] msg, input logic [1:0] mem,
                         input logic [1:0] other_st, input int fw, input int mw,
                         input logic [1:0] also_bus, input string tag);
    logic [W-1:0] e;
    int cyc;
    push_txn(owner, msg, other_st, fw, mw);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      if (cyc == 0) begin
        if (owner) begin
          req1_bus = msg; req1_mem = mem; state0 = other_st;
          if (also_bus != 2'b00) req0_bus = also_bus;
        end else begin
          req0_bus = msg; req0_mem = mem; state1 = other_st;
          if (also_bus != 2'b00) req1_bus = also_bus;
        end
      end
      mem_ready = mr_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h required %h", tag, cyc, observed(), e);
      end
      if (e[CNT_W]) begin
        if (owner) begin req1_bus = 2'b00; req1_mem = 2'b00; end
        else       begin req0_bus = 2'b00; req0_mem = 2'b00; end
      end
      cyc++;
    end
  endtask

  task automatic clear_inputs();
    req0_bus = 2'b00; req0_mem = 2'b00; req1_bus = 2'b00; req1_mem = 2'b00;
    state0 = 2'b00; state1 = 2'b00; mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    exp_count = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    exp_count = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ((observed() !== '0) || (dbg_state !== ST_IDLE)) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%0d required 0/%0d", observed(), dbg_state, ST_IDLE);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_bus_rd();
    run_txn(1'b0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, "busrd_c0");
  endtask

  task automatic test_reset_mid_mem();
    @(negedge clock);
    req0_bus = 2'b01; state1 = 2'b00; mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({grant, mem_cmd} !== 4'b0101 || dbg_state !== ST_MEM) begin
      n_fail++;
      $display("FAIL mid_mem_setup: got grant/mem_cmd %b state %0d required 0101 state %0d",
               {grant, mem_cmd}, dbg_state, ST_MEM);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ((observed() !== '0) || (dbg_state !== ST_IDLE)) begin
      n_fail++;
      $display("FAIL reset_mid_mem: got %h/%0d required 0/%0d", observed(), dbg_state, ST_IDLE);
    end
    clear_inputs();
    exp_count = '0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      n_checks++;
      if ((observed() !== '0) || (dbg_state !== ST_IDLE)) begin
        n_fail++;
        $display("FAIL idle_after_reset: got %h/%0d required 0/%0d", observed(), dbg_state, ST_IDLE);
      end
    end
  endtask

  task automatic test_simultaneous();
    run_txn(1'b0, 2'b01, 2'b00, 2'b01, 0, 0, 2'b01, "pair1_c0");
    run_txn(1'b1, 2'b01, 2'b00, 2'b10, 0, 0, 2'b00, "pair1_c1");
    run_txn(1'b0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b01, "pair2_c0");
    run_txn(1'b1, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, "pair2_c1");
  endtask

  task automatic test_flush();
    run_txn(1'b1, 2'b10, 2'b00, 2'b11, 2, 0, 2'b00, "rdx_remote_m");
    run_txn(1'b0, 2'b01, 2'b00, 2'b11, 0, 1, 2'b00, "rd_remote_m");
  endtask

  task automatic test_upgrade_and_writeback();
    run_txn(1'b0, 2'b11, 2'b00, 2'b01, 0, 0, 2'b00, "upgr_shared");
    run_txn(1'b1, 2'b00, 2'b10, 2'b00, 0, 0, 2'b00, "wb_only");
    run_txn(1'b1, 2'b11, 2'b00, 2'b11, 1, 0, 2'b00, "upgr_remote_m");
    run_txn(1'b0, 2'b10, 2'b10, 2'b00, 0, 0, 2'b00, "bus_over_wb");
  endtask

  task automatic test_illegal_mem();
    @(negedge clock);
    req0_mem = 2'b01; req1_mem = 2'b11;
    repeat (4) begin
      @(negedge clock);
      n_checks++;
      if ((observed() !== pack(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, exp_count)) ||
          (dbg_state !== ST_IDLE)) begin
        n_fail++;
        $display("FAIL illegal_mem: got %h/%0d required idle", observed(), dbg_state);
      end
    end
    req0_mem = 2'b00; req1_mem = 2'b00;
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_txn(1'(i % 2), 2'b11, 2'b00, 2'(i % 3), 0, 0, 2'b00, "wrap");
    end
    n_checks++;
    if (txn_count !== '0) begin
      n_fail++;
      $display("FAIL wrap_final: got %0d required 0", txn_count);
    end
  endtask

  // Test sequence and summary
  initial begin
    test_reset();
    test_bus_rd();
    test_reset_mid_mem();
    test_simultaneous();
    test_flush();
    test_upgrade_and_writeback();
    test_illegal_mem();
    test_back_to_back_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
